// File: rtl/iob_rr_merge_pkg.sv
// Shared definitions for the round-robin iob merge: FSM encoding and bus width helpers.
package iob_rr_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Request slice layout, MSB first: {valid, addr, wdata, wstrb}.
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response slice layout, MSB first: {rdata, ready}.
    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_merge_if.sv
// Packed native-iob buses between N masters, the merge block and the shared slave.
interface iob_rr_merge_if
    import iob_rr_merge_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int REQ_W  = req_width(ADDR_W, DATA_W);
    localparam int RESP_W = resp_width(DATA_W);

    // Handshake: a request is held while valid until the paired ready is seen for one
    // cycle; ready carries rdata in that same cycle and is 0 with rdata 0 otherwise.
    logic [N_MASTERS*REQ_W-1:0]  m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]            s_req;
    logic [RESP_W-1:0]           s_resp;

    // Arbiter side.
    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req
    );

    // Environment side: the masters plus the shared slave.
    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req
    );

endinterface

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first valid index scanning rr_ptr, rr_ptr+1, ... mod N.
module iob_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any_valid,
    output logic [IDX_W-1:0] winner
);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest valid index is assigned last.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        sum       = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            idx = sum[IDX_W-1:0];
            if (valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

endmodule

// File: rtl/iob_rr_merge.sv
// Merges N native-iob masters onto one slave, one outstanding transaction at a time,
// with round-robin fairness (last-served master gets lowest priority next).
module iob_rr_merge
    import iob_rr_merge_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    iob_rr_merge_if.slave bus,
    output state_t        fsm_state
);
    localparam int REQ_W  = req_width(ADDR_W, DATA_W);
    localparam int RESP_W = resp_width(DATA_W);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(N_MASTERS);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [IDX_W-1:0]   grant_idx, grant_idx_nx;
    logic [ADDR_W-1:0]  addr_q, addr_nx;
    logic [DATA_W-1:0]  wdata_q, wdata_nx;
    logic [STRB_W-1:0]  wstrb_q, wstrb_nx;

    logic [N_MASTERS-1:0] valid_vec;
    logic [ADDR_W-1:0]    addr_arr  [N_MASTERS];
    logic [DATA_W-1:0]    wdata_arr [N_MASTERS];
    logic [STRB_W-1:0]    wstrb_arr [N_MASTERS];

    logic                 any_valid;
    logic [IDX_W-1:0]     winner;
    logic                 s_ready;
    logic [DATA_W-1:0]    s_rdata;
    logic [N_MASTERS*RESP_W-1:0] resp_vec;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            valid_vec[i] = bus.m_req[i*REQ_W + REQ_W - 1];
            addr_arr[i]  = bus.m_req[i*REQ_W + STRB_W + DATA_W +: ADDR_W];
            wdata_arr[i] = bus.m_req[i*REQ_W + STRB_W +: DATA_W];
            wstrb_arr[i] = bus.m_req[i*REQ_W +: STRB_W];
        end
    end

    assign s_ready = bus.s_resp[0];
    assign s_rdata = bus.s_resp[RESP_W-1:1];

    iob_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid     (valid_vec),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .winner    (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            grant_idx <= grant_idx_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            wstrb_q   <= wstrb_nx;
        end
    end

    // The request is always registered first, so the slave never sees a master combinationally.
    always_comb begin
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        grant_idx_nx = grant_idx;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        wstrb_nx     = wstrb_q;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    grant_idx_nx = winner;
                    addr_nx      = addr_arr[winner];
                    wdata_nx     = wdata_arr[winner];
                    wstrb_nx     = wstrb_arr[winner];
                    state_nx     = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    rr_ptr_nx = (grant_idx == IDX_W'(N_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        resp_vec = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (state == BUSY && s_ready && grant_idx == IDX_W'(i)) begin
                resp_vec[i*RESP_W +: RESP_W] = {s_rdata, 1'b1};
            end
        end
    end

    assign bus.m_resp = resp_vec;
    assign bus.s_req  = (state == BUSY) ? {1'b1, addr_q, wdata_q, wstrb_q} : '0;
    assign fsm_state  = state;

endmodule

// File: tb/tb_iob_rr_merge.sv
// Bench for iob_rr_merge with four masters: directed cycle table, then random traffic
// checked against a transaction-level round-robin model.
module tb_iob_rr_merge;
  import iob_rr_merge_pkg::*;

  localparam int N      = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int REQ_W  = 1 + AW + DW + SW;
  localparam int RESP_W = DW + 1;
  localparam int QW     = 2 + AW + DW + SW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iob_rr_merge_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  state_t fsm_state;

  iob_rr_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // driver state
  logic          m_valid [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];
  logic [SW-1:0] m_wstrb [N];
  logic          s_ready;
  logic [DW-1:0] s_rdata;

  int total = 0;
  int bad   = 0;

  // scoreboard: in-flight expected slave request {master, addr, wdata, wstrb}
  logic [QW-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] addr1;
    logic        sr;
    logic [31:0] rdata;
    logic        esv;
    int          esm;
    logic [31:0] eaddr;
    logic [3:0]  erdy;
    logic [31:0] erdata;
  } vec_t;
  vec_t tbl[$];

  logic [DW-1:0] fix_wdata [N];
  logic [SW-1:0] fix_wstrb [N];
  logic [AW-1:0] fix_addr  [N];

  task automatic drive();
    for (int i = 0; i < N; i++)
      bus.m_req[i*REQ_W +: REQ_W] = {m_valid[i], m_addr[i], m_wdata[i], m_wstrb[i]};
    bus.s_resp = {s_rdata, s_ready};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int i);
    return bus.m_resp[i*RESP_W];
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int i);
    return bus.m_resp[i*RESP_W+1 +: DW];
  endfunction

  function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] a1,
                              input logic sr, input logic [31:0] rd, input logic esv,
                              input int esm, input logic [31:0] ea, input logic [3:0] er,
                              input logic [31:0] erd);
    vec_t t;
    t.rst = r; t.valid = v; t.addr1 = a1; t.sr = sr; t.rdata = rd;
    t.esv = esv; t.esm = esm; t.eaddr = ea; t.erdy = er; t.erdata = erd;
    tbl.push_back(t);
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
    end
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  // random-phase master state
  logic act  [N];
  logic cool [N];
  int   last_served;
  int   dut_done;
  int   exp_done;

  initial begin
    fix_addr[0] = 32'h100; fix_wdata[0] = 32'h1234_5678; fix_wstrb[0] = 4'hF;
    fix_addr[1] = 32'h0;   fix_wdata[1] = 32'h0;         fix_wstrb[1] = 4'h0;
    fix_addr[2] = 32'h300; fix_wdata[2] = 32'hCAFE_0002; fix_wstrb[2] = 4'h3;
    fix_addr[3] = 32'h400; fix_wdata[3] = 32'hCAFE_0003; fix_wstrb[3] = 4'hC;

    // reset release, spurious ready
    add(0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b0000, 32'h0, 1, 32'hAAAA, 0, 0, 32'h0, 4'b0000, 32'h0);
    // single read from master 1, slave ready three cycles after the request
    add(0, 4'b0010, 32'h8000_0010, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b0010, 32'h8000_0010, 0, 32'h0, 1, 1, 32'h8000_0010, 4'b0000, 32'h0);
    add(0, 4'b0010, 32'h8000_0010, 0, 32'h0, 1, 1, 32'h8000_0010, 4'b0000, 32'h0);
    add(0, 4'b0010, 32'h8000_0010, 1, 32'hDEAD_BEEF, 1, 1, 32'h8000_0010, 4'b0010, 32'hDEAD_BEEF);
    add(0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    // simultaneous m0 write and m1 read
    add(0, 4'b0011, 32'h200, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b0011, 32'h200, 1, 32'h11, 1, 0, 32'h100, 4'b0001, 32'h11);
    add(0, 4'b0010, 32'h200, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b0010, 32'h200, 1, 32'h22, 1, 1, 32'h200, 4'b0010, 32'h22);
    add(0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    // request stability: master drops valid and scribbles addr during a 5-cycle stall
    add(0, 4'b0010, 32'h44, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    for (int k = 0; k < 5; k++)
      add(0, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0, 1, 1, 32'h44, 4'b0000, 32'h0);
    add(0, 4'b0000, 32'hFFFF_FFFF, 1, 32'h55, 1, 1, 32'h44, 4'b0010, 32'h55);
    add(0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    // reset mid-BUSY: pointer returns to master 0
    add(0, 4'b1000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(1, 4'b1000, 32'h0, 0, 32'h0, 1, 3, 32'h400, 4'b0000, 32'h0);
    add(0, 4'b1001, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1001, 32'h0, 1, 32'h66, 1, 0, 32'h100, 4'b0001, 32'h66);
    add(0, 4'b1000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1000, 32'h0, 1, 32'h77, 1, 3, 32'h400, 4'b1000, 32'h77);
    add(0, 4'b0000, 32'h0, 1, 32'h78, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
    // fairness: all four continuously valid, zero-wait slave
    add(0, 4'b1111, 32'h200, 1, 32'h80, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1111, 32'h200, 1, 32'h81, 1, 0, 32'h100, 4'b0001, 32'h81);
    add(0, 4'b1111, 32'h200, 1, 32'h82, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1111, 32'h200, 1, 32'h83, 1, 1, 32'h200, 4'b0010, 32'h83);
    add(0, 4'b1111, 32'h200, 1, 32'h84, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1111, 32'h200, 1, 32'h85, 1, 2, 32'h300, 4'b0100, 32'h85);
    add(0, 4'b1111, 32'h200, 1, 32'h86, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1111, 32'h200, 1, 32'h87, 1, 3, 32'h400, 4'b1000, 32'h87);
    add(0, 4'b1111, 32'h200, 1, 32'h88, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(0, 4'b1111, 32'h200, 1, 32'h89, 1, 0, 32'h100, 4'b0001, 32'h89);
    add(0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);

    // initial reset: everything must be 0 from the first edge with rst high
    rst = 1'b1;
    idle_inputs();
    drive();
    @(posedge clk);
    @(negedge clk);
    check("reset_s_req", bus.s_req, '0);
    check("reset_m_resp", bus.m_resp, '0);
    check("reset_state", fsm_state, IDLE);
    @(posedge clk);

    // directed table
    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clk);
      #1;
      rst = tbl[r].rst;
      for (int i = 0; i < N; i++) begin
        m_valid[i] = tbl[r].valid[i];
        m_addr[i]  = (i == 1) ? tbl[r].addr1 : fix_addr[i];
        m_wdata[i] = fix_wdata[i];
        m_wstrb[i] = fix_wstrb[i];
      end
      s_ready = tbl[r].sr;
      s_rdata = tbl[r].rdata;
      drive();
      @(negedge clk);
      check($sformatf("row%0d_s_valid", r), bus.s_req[REQ_W-1], tbl[r].esv);
      check($sformatf("row%0d_state", r), fsm_state, tbl[r].esv ? BUSY : IDLE);
      if (tbl[r].esv) begin
        check($sformatf("row%0d_s_addr", r), bus.s_req[SW+DW +: AW], tbl[r].eaddr);
        check($sformatf("row%0d_s_wdata", r), bus.s_req[SW +: DW], fix_wdata[tbl[r].esm]);
        check($sformatf("row%0d_s_wstrb", r), bus.s_req[SW-1:0], fix_wstrb[tbl[r].esm]);
      end
      for (int i = 0; i < N; i++) begin
        check($sformatf("row%0d_m%0d_ready", r, i), get_ready(i), tbl[r].erdy[i]);
        check($sformatf("row%0d_m%0d_rdata", r, i), get_rdata(i),
              tbl[r].erdy[i] ? tbl[r].erdata : 32'h0);
      end
    end

    // random traffic against the transaction-level model
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      cool[i] = 1'b0;
    end
    exp_q.delete();
    last_served = N - 1;
    dut_done = 0;
    exp_done = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (cool[i]) begin
          cool[i] = 1'b0;
        end else if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i]     = 1'b1;
          m_addr[i]  = $urandom;
          m_wdata[i] = $urandom;
          m_wstrb[i] = 4'($urandom_range(0, 15));
        end
        m_valid[i] = act[i];
      end
      s_ready = ($urandom_range(0, 1) == 1);
      s_rdata = $urandom;
      drive();
      @(negedge clk);

      check($sformatf("rnd%0d_s_valid", cyc), bus.s_req[REQ_W-1], exp_q.size() != 0);
      if (exp_q.size() != 0)
        check($sformatf("rnd%0d_s_payload", cyc), bus.s_req[REQ_W-2:0], exp_q[0][QW-3:0]);
      for (int i = 0; i < N; i++) begin
        logic exp_rdy;
        exp_rdy = (exp_q.size() != 0) && s_ready && (int'(exp_q[0][QW-1:QW-2]) == i);
        check($sformatf("rnd%0d_m%0d_ready", cyc, i), get_ready(i), exp_rdy);
        check($sformatf("rnd%0d_m%0d_rdata", cyc, i), get_rdata(i), exp_rdy ? s_rdata : '0);
        if (get_ready(i)) begin
          act[i] = 1'b0;
          cool[i] = 1'b1;
          dut_done++;
        end
      end

      // model: one transaction in flight; last-served master has lowest priority
      if (exp_q.size() != 0) begin
        if (s_ready) begin
          last_served = int'(exp_q[0][QW-1:QW-2]);
          void'(exp_q.pop_front());
          exp_done++;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (last_served + k) % N;
          if (m_valid[j] && exp_q.size() == 0)
            exp_q.push_back({2'(j), m_addr[j], m_wdata[j], m_wstrb[j]});
        end
      end
    end
    check("rnd_completions", dut_done, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
